// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states and request-source tags.
package mem_arb_pkg;
   typedef enum logic [1:0] {ARB, HOLD_I, HOLD_D} arb_state_t;
   typedef enum logic {SRC_I = 1'b0, SRC_D = 1'b1} arb_src_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-port handshake bundle around the arbiter.
// slave = arbiter view; master = the core/memory environment driving it.
interface mem_port_arbiter_if #(
   parameter int C_BUS_SZ = 32,
   parameter int C_BE_SZ  = C_BUS_SZ/8
);
   logic                ireqready_o, ireqvalid_i;
   logic [1:0]          ireqhpl_i;
   logic [C_BUS_SZ-1:0] ireqaddr_i;
   logic                irspready_i, irspvalid_o, irsprerr_o;
   logic [C_BUS_SZ-1:0] irspdata_o;

   logic                dreqready_o, dreqvalid_i;
   logic [1:0]          dreqhpl_i;
   logic [C_BUS_SZ-1:0] dreqaddr_i;
   logic                dreqwe_i;
   logic [C_BE_SZ-1:0]  dreqbe_i;
   logic [C_BUS_SZ-1:0] dreqdata_i;
   logic                drspready_i, drspvalid_o, drsprerr_o;
   logic [C_BUS_SZ-1:0] drspdata_o;

   logic                mreqready_i, mreqvalid_o;
   logic [1:0]          mreqhpl_o;
   logic [C_BUS_SZ-1:0] mreqaddr_o;
   logic                mreqwe_o;
   logic [C_BE_SZ-1:0]  mreqbe_o;
   logic [C_BUS_SZ-1:0] mreqdata_o;
   logic                mrspready_o, mrspvalid_i, mrsprerr_i;
   logic [C_BUS_SZ-1:0] mrspdata_i;

   modport slave (
      input  ireqvalid_i, ireqhpl_i, ireqaddr_i, irspready_i,
      output ireqready_o, irspvalid_o, irsprerr_o, irspdata_o,
      input  dreqvalid_i, dreqhpl_i, dreqaddr_i, dreqwe_i, dreqbe_i, dreqdata_i, drspready_i,
      output dreqready_o, drspvalid_o, drsprerr_o, drspdata_o,
      input  mreqready_i, mrspvalid_i, mrsprerr_i, mrspdata_i,
      output mreqvalid_o, mreqhpl_o, mreqaddr_o, mreqwe_o, mreqbe_o, mreqdata_o, mrspready_o
   );

   modport master (
      output ireqvalid_i, ireqhpl_i, ireqaddr_i, irspready_i,
      input  ireqready_o, irspvalid_o, irsprerr_o, irspdata_o,
      output dreqvalid_i, dreqhpl_i, dreqaddr_i, dreqwe_i, dreqbe_i, dreqdata_i, drspready_i,
      input  dreqready_o, drspvalid_o, drsprerr_o, drspdata_o,
      output mreqready_i, mrspvalid_i, mrsprerr_i, mrspdata_i,
      input  mreqvalid_o, mreqhpl_o, mreqaddr_o, mreqwe_o, mreqbe_o, mreqdata_o, mrspready_o
   );
endinterface

// File: rtl/mem_port_arbiter_fifo.sv
// Small circular FIFO; occupancy is tracked by the instantiating block.
module mem_port_arbiter_fifo #(
   parameter int C_FIFO_WIDTH   = 1,
   parameter int C_FIFO_DEPTH_X = 2
) (
   input  logic                    clk_i,
   input  logic                    resetb_i,
   input  logic                    flush_i,
   input  logic                    wrreq_i,
   input  logic [C_FIFO_WIDTH-1:0] wrdata_i,
   input  logic                    rdreq_i,
   output logic [C_FIFO_WIDTH-1:0] rddata_o
);
   logic [2**C_FIFO_DEPTH_X-1:0][C_FIFO_WIDTH-1:0] mem_q;
   logic [C_FIFO_DEPTH_X-1:0]                      wrptr_q, rdptr_q;

   always_ff @(posedge clk_i or negedge resetb_i) begin
      if (!resetb_i) begin
         wrptr_q <= '0;
         rdptr_q <= '0;
      end else if (flush_i) begin
         wrptr_q <= '0;
         rdptr_q <= '0;
      end else begin
         if (wrreq_i) wrptr_q <= wrptr_q + 1'b1;
         if (rdreq_i) rdptr_q <= rdptr_q + 1'b1;
      end
   end

   // Storage needs no reset: reads are only meaningful while the owner's level is non-zero.
   always_ff @(posedge clk_i) begin
      if (wrreq_i) mem_q[wrptr_q] <= wrdata_i;
   end

   assign rddata_o = mem_q[rdptr_q];
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one in-order memory port between fetch (I) and data (D); D has priority with a
// starvation guard for I. A tag queue routes in-order responses back to their source.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int C_BUS_SZX    = 5,
   parameter int C_OSTD_X     = 2,
   parameter int C_STARVE_MAX = 4
) (
   input logic          clk_i,
   input logic          resetb_i,
   input logic          clk_en_i,
   mem_port_arbiter_if.slave bus
);
   localparam int C_BUS_SZ = 2**C_BUS_SZX;
   localparam int C_BE_SZ  = C_BUS_SZ/8;
   localparam int SW       = $clog2(C_STARVE_MAX+1);
   localparam logic [SW-1:0]       STARVE_TOP = SW'(C_STARVE_MAX);
   localparam logic [C_OSTD_X:0]   LVL_FULL   = (C_OSTD_X+1)'(2**C_OSTD_X);

   arb_state_t        state_q, state_d;
   logic [SW-1:0]     starve_q;
   logic [C_OSTD_X:0] level_q;
   logic              tagq_full, tagq_empty, req_ok;
   logic              grant_i, grant_d, mreqvalid, fire, rsp_ready, pop;
   logic              head_bit;
   arb_src_t          head;

   assign tagq_full  = (level_q == LVL_FULL);
   assign tagq_empty = (level_q == '0);
   assign req_ok     = clk_en_i & ~tagq_full;

   always_comb begin
      state_d = state_q;
      grant_i = 1'b0;
      grant_d = 1'b0;
      case (state_q)
         ARB: begin
            if (bus.dreqvalid_i && starve_q != STARVE_TOP) grant_d = 1'b1;
            else if (bus.ireqvalid_i)                      grant_i = 1'b1;
         end
         HOLD_I:  grant_i = bus.ireqvalid_i;
         HOLD_D:  grant_d = bus.dreqvalid_i;
         default: ;
      endcase
      mreqvalid = req_ok & (grant_i | grant_d);
      fire      = mreqvalid & bus.mreqready_i;
      // A full queue or a stalled clock leaves the FSM where it is.
      if (req_ok) begin
         if (fire || !mreqvalid) state_d = ARB;
         else                    state_d = grant_d ? HOLD_D : HOLD_I;
      end
   end

   always_ff @(posedge clk_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_q  <= ARB;
         starve_q <= '0;
         level_q  <= '0;
      end else if (clk_en_i) begin
         state_q <= state_d;
         if (fire && grant_i)                              starve_q <= '0;
         else if (bus.ireqvalid_i && starve_q != STARVE_TOP) starve_q <= starve_q + 1'b1;
         case ({fire, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: ;
         endcase
      end
   end

   mem_port_arbiter_fifo #(
      .C_FIFO_WIDTH   (1),
      .C_FIFO_DEPTH_X (C_OSTD_X)
   ) u_tagq (
      .clk_i    (clk_i),
      .resetb_i (resetb_i),
      .flush_i  (1'b0),
      .wrreq_i  (fire),
      .wrdata_i (grant_d),
      .rdreq_i  (pop),
      .rddata_o (head_bit)
   );

   assign bus.mreqvalid_o = mreqvalid;
   assign bus.ireqready_o = mreqvalid & grant_i & bus.mreqready_i;
   assign bus.dreqready_o = mreqvalid & grant_d & bus.mreqready_i;
   assign bus.mreqhpl_o   = grant_d ? bus.dreqhpl_i  : bus.ireqhpl_i;
   assign bus.mreqaddr_o  = grant_d ? bus.dreqaddr_i : bus.ireqaddr_i;
   assign bus.mreqwe_o    = grant_d & bus.dreqwe_i;
   assign bus.mreqbe_o    = grant_d ? bus.dreqbe_i   : {C_BE_SZ{1'b1}};
   assign bus.mreqdata_o  = grant_d ? bus.dreqdata_i : {C_BUS_SZ{1'b0}};

   assign head      = arb_src_t'(head_bit);
   assign rsp_ready = clk_en_i & ~tagq_empty & ((head == SRC_D) ? bus.drspready_i : bus.irspready_i);
   assign pop       = bus.mrspvalid_i & rsp_ready;

   assign bus.mrspready_o = rsp_ready;
   assign bus.irspvalid_o = clk_en_i & bus.mrspvalid_i & ~tagq_empty & (head == SRC_I);
   assign bus.drspvalid_o = clk_en_i & bus.mrspvalid_i & ~tagq_empty & (head == SRC_D);
   assign bus.irsprerr_o  = bus.mrsprerr_i;
   assign bus.drsprerr_o  = bus.mrsprerr_i;
   assign bus.irspdata_o  = bus.mrspdata_i;
   assign bus.drspdata_o  = bus.mrspdata_i;

   // A response with nothing outstanding means the memory side broke ordering.
   a_rsp_has_tag: assert property (@(posedge clk_i) disable iff (!resetb_i)
      !(clk_en_i && bus.mrspvalid_i && tagq_empty));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus random traffic, checked against a queue-based reference model.
module tb_mem_port_arbiter;
   localparam int DEPTH = 4;
   localparam int SMAX  = 4;

   logic clk = 1'b0, resetb = 1'b0, clk_en = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.C_BUS_SZ(32)) bus ();
   mem_port_arbiter #(.C_BUS_SZX(5), .C_OSTD_X(2), .C_STARVE_MAX(SMAX)) dut (
      .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en), .bus(bus));

   int tests = 0, fails = 0;
   int mq[$];            // outstanding sources in issue order: 1=I, 2=D
   int starve = 0, lock = 0;
   bit rsp_en = 1'b0;
   int obs_side;
   logic obs_mv, obs_irv, obs_drv, obs_mrdy, obs_drdy;
   logic [31:0] obs_addr, obs_irdata;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0b want %0b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.ireqvalid_i = 0; bus.ireqhpl_i = 0; bus.ireqaddr_i = 0; bus.irspready_i = 1;
      bus.dreqvalid_i = 0; bus.dreqhpl_i = 0; bus.dreqaddr_i = 0; bus.dreqwe_i = 0;
      bus.dreqbe_i = 0; bus.dreqdata_i = 0; bus.drspready_i = 1;
      bus.mreqready_i = 1; bus.mrspvalid_i = 0; bus.mrsprerr_i = 0; bus.mrspdata_i = 0;
      rsp_en = 0;
   endtask

   // One clock: check outputs against the model, then advance the model. Entered at negedge.
   task automatic cycle();
      int side, head;
      bit full, empty, mv, fire, rv, mrdy;
      bus.mrspvalid_i = rsp_en && (mq.size() != 0);
      #1;
      full  = (mq.size() == DEPTH);
      empty = (mq.size() == 0);
      side  = 0;
      if (clk_en && !full) begin
         if (lock != 0)                                side = lock;
         else if (bus.dreqvalid_i && starve != SMAX)   side = 2;
         else if (bus.ireqvalid_i)                     side = 1;
      end
      mv   = (side != 0);
      fire = mv && bus.mreqready_i;
      head = empty ? 0 : mq[0];
      rv   = clk_en && bus.mrspvalid_i && !empty;
      mrdy = clk_en && !empty && ((head == 2) ? bus.drspready_i : bus.irspready_i);

      chk1("mreqvalid", bus.mreqvalid_o, mv);
      chk1("ireqready", bus.ireqready_o, side == 1 && bus.mreqready_i);
      chk1("dreqready", bus.dreqready_o, side == 2 && bus.mreqready_i);
      if (mv) begin
         chkw("mreqaddr", bus.mreqaddr_o, (side == 2) ? bus.dreqaddr_i : bus.ireqaddr_i);
         chkw("mreqhpl", 32'(bus.mreqhpl_o), (side == 2) ? 32'(bus.dreqhpl_i) : 32'(bus.ireqhpl_i));
         chk1("mreqwe", bus.mreqwe_o, side == 2 && bus.dreqwe_i);
         chkw("mreqbe", 32'(bus.mreqbe_o), (side == 2) ? 32'(bus.dreqbe_i) : 32'hF);
         chkw("mreqdata", bus.mreqdata_o, (side == 2) ? bus.dreqdata_i : 32'h0);
      end
      chk1("irspvalid", bus.irspvalid_o, rv && head == 1);
      chk1("drspvalid", bus.drspvalid_o, rv && head == 2);
      chk1("mrspready", bus.mrspready_o, mrdy);
      if (rv) begin
         chkw("rspdata", (head == 2) ? bus.drspdata_o : bus.irspdata_o, bus.mrspdata_i);
         chk1("rsprerr", (head == 2) ? bus.drsprerr_o : bus.irsprerr_o, bus.mrsprerr_i);
      end

      obs_side   = bus.ireqready_o ? 1 : (bus.dreqready_o ? 2 : 0);
      obs_mv     = bus.mreqvalid_o;
      obs_irv    = bus.irspvalid_o;
      obs_drv    = bus.drspvalid_o;
      obs_mrdy   = bus.mrspready_o;
      obs_drdy   = bus.dreqready_o;
      obs_addr   = bus.mreqaddr_o;
      obs_irdata = bus.irspdata_o;

      if (clk_en) begin
         if (bus.mrspvalid_i && mrdy) void'(mq.pop_front());
         if (fire) begin
            mq.push_back(side);
            lock = 0;
         end else if (mv) lock = side;
         if (fire && side == 1)                    starve = 0;
         else if (bus.ireqvalid_i && starve < SMAX) starve++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      bus.ireqvalid_i = 0; bus.dreqvalid_i = 0;
      bus.irspready_i = 1; bus.drspready_i = 1; rsp_en = 1;
      for (int k = 0; k < 8 && mq.size() != 0; k++) cycle();
      rsp_en = 0;
   endtask

   initial begin
      int exp2 [6] = '{2, 2, 2, 2, 1, 2};
      idle();
      // Reset: empty queue, so even a response strobe must not be accepted or routed.
      bus.mrspvalid_i = 1;
      #1;
      chk1("rst mreqvalid", bus.mreqvalid_o, 1'b0);
      chk1("rst mrspready", bus.mrspready_o, 1'b0);
      chk1("rst irspvalid", bus.irspvalid_o, 1'b0);
      chk1("rst drspvalid", bus.drspvalid_o, 1'b0);
      @(negedge clk);
      bus.mrspvalid_i = 0;
      resetb = 1;

      // 1: fetch-only stream, then in-order responses to fetch
      bus.ireqvalid_i = 1;
      for (int k = 0; k < 3; k++) begin
         bus.ireqaddr_i = 32'h100 + 32'(4*k);
         cycle();
         chkw("t1 side", 32'(obs_side), 32'd1);
         chkw("t1 addr", obs_addr, 32'h100 + 32'(4*k));
      end
      bus.ireqvalid_i = 0;
      rsp_en = 1;
      for (int k = 0; k < 3; k++) begin
         bus.mrspdata_i = 32'hA + 32'(k);
         cycle();
         chk1("t1 irspvalid", obs_irv, 1'b1);
         chk1("t1 drspvalid", obs_drv, 1'b0);
         chkw("t1 irspdata", obs_irdata, 32'hA + 32'(k));
      end

      // 2: both valid -> starvation guard lets fetch in after four data grants
      bus.ireqvalid_i = 1; bus.ireqaddr_i = 32'h200;
      bus.dreqvalid_i = 1; bus.dreqaddr_i = 32'h300; bus.dreqwe_i = 1;
      bus.dreqbe_i = 4'h3; bus.dreqdata_i = 32'hDEAD;
      for (int k = 0; k < 6; k++) begin
         cycle();
         chkw("t2 grant", 32'(obs_side), 32'(exp2[k]));
      end
      drain();

      // 3: memory stalls a data request; grant and payload stay on D
      bus.mreqready_i = 0;
      bus.dreqvalid_i = 1; bus.dreqaddr_i = 32'h400; bus.dreqwe_i = 0;
      bus.ireqvalid_i = 1; bus.ireqaddr_i = 32'h500;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk1("t3 mreqvalid", obs_mv, 1'b1);
         chkw("t3 addr", obs_addr, 32'h400);
         chk1("t3 dreqready", obs_drdy, 1'b0);
      end
      bus.mreqready_i = 1;
      cycle();
      chkw("t3 fire", 32'(obs_side), 32'd2);
      bus.dreqvalid_i = 0;
      cycle();
      chkw("t3 then I", 32'(obs_side), 32'd1);
      drain();

      // 4: fill the tag queue I,D,I,D; further requests wait for a free slot
      for (int k = 0; k < 4; k++) begin
         bus.ireqvalid_i = (k % 2 == 0); bus.ireqaddr_i = 32'h600 + 32'(k);
         bus.dreqvalid_i = (k % 2 == 1); bus.dreqaddr_i = 32'h700 + 32'(k);
         cycle();
         chkw("t4 fill", 32'(obs_side), (k % 2 == 1) ? 32'd2 : 32'd1);
      end
      bus.ireqvalid_i = 0; bus.dreqvalid_i = 1; bus.dreqaddr_i = 32'h800;
      cycle();
      chk1("t4 full blocks", obs_mv, 1'b0);
      rsp_en = 1;
      cycle();
      chk1("t4 pop while full", obs_mrdy, 1'b1);
      chk1("t4 still blocked", obs_mv, 1'b0);
      cycle();
      chkw("t4 push+pop", 32'(obs_side), 32'd2);
      chk1("t4 push+pop rsp", obs_mrdy, 1'b1);
      rsp_en = 0; bus.dreqvalid_i = 0; bus.ireqvalid_i = 1; bus.ireqaddr_i = 32'h900;
      cycle();
      chkw("t4 refill", 32'(obs_side), 32'd1);
      bus.ireqaddr_i = 32'h904;
      cycle();
      chk1("t4 full again", obs_mv, 1'b0);
      bus.ireqvalid_i = 0;

      // 5: head is data but data side not ready -> response waits, never misrouted
      rsp_en = 1; bus.irspready_i = 1; bus.drspready_i = 0;
      cycle();
      chk1("t5 I pop", obs_irv, 1'b1);
      for (int k = 0; k < 2; k++) begin
         cycle();
         chk1("t5 mrspready", obs_mrdy, 1'b0);
         chk1("t5 irspvalid", obs_irv, 1'b0);
         chk1("t5 drspvalid", obs_drv, 1'b1);
      end
      bus.drspready_i = 1;
      cycle();
      chk1("t5 released", obs_mrdy, 1'b1);
      rsp_en = 0;

      // 6: reset with two outstanding drops them
      resetb = 0;
      mq.delete(); starve = 0; lock = 0;
      bus.mrspvalid_i = 1;
      #1;
      chk1("t6 mrspready", bus.mrspready_o, 1'b0);
      chk1("t6 irspvalid", bus.irspvalid_o, 1'b0);
      chk1("t6 drspvalid", bus.drspvalid_o, 1'b0);
      chk1("t6 mreqvalid", bus.mreqvalid_o, 1'b0);
      @(negedge clk);
      bus.mrspvalid_i = 0;
      resetb = 1;
      bus.ireqvalid_i = 1; bus.ireqaddr_i = 32'hA00;
      cycle();
      chkw("t6 post-reset grant", 32'(obs_side), 32'd1);
      drain();

      // Random traffic; requesters hold valid/payload until accepted
      for (int n = 0; n < 800; n++) begin
         clk_en = ($urandom_range(0, 7) != 0);
         if (!bus.ireqvalid_i && $urandom_range(0, 1) == 1) begin
            bus.ireqvalid_i = 1;
            bus.ireqaddr_i  = $urandom;
            bus.ireqhpl_i   = 2'($urandom_range(0, 3));
         end
         if (!bus.dreqvalid_i && $urandom_range(0, 1) == 1) begin
            bus.dreqvalid_i = 1;
            bus.dreqaddr_i  = $urandom;
            bus.dreqhpl_i   = 2'($urandom_range(0, 3));
            bus.dreqwe_i    = 1'($urandom_range(0, 1));
            bus.dreqbe_i    = 4'($urandom);
            bus.dreqdata_i  = $urandom;
         end
         bus.mreqready_i = ($urandom_range(0, 3) != 0);
         rsp_en          = ($urandom_range(0, 2) != 0);
         bus.irspready_i = ($urandom_range(0, 3) != 0);
         bus.drspready_i = ($urandom_range(0, 3) != 0);
         bus.mrspdata_i  = $urandom;
         bus.mrsprerr_i  = 1'($urandom_range(0, 1));
         cycle();
         if (obs_side == 1) bus.ireqvalid_i = 0;
         if (obs_side == 2) bus.dreqvalid_i = 0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
